// File: rtl/player_sequencer.sv
// player_sequencer
// ----------------
// Note sequencer for the music player. Walks a synchronous note ROM one
// track at a time, times each note's duration in units of TICK_DIV clock
// cycles, and drives pitch / tone enable to the tone generator. Track
// selection follows rising edges of the debounced next/prev buttons.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   play       in   1 = play, 0 = pause (level from the play/pause FSM)
//   next_btn   in   debounced level; rising edge selects the next track
//   prev_btn   in   debounced level; rising edge selects the previous track
//   rom_addr   out  {track, note_idx}, combinational from registers
//   rom_data   in   {pitch[9:4], dur[3:0]}, valid one cycle after rom_addr;
//                   dur == 0 marks the end of a track
//   pitch_out  out  registered pitch of the current note
//   tone_en    out  high only while a note is sounding
//   track      out  current track index
//   note_idx   out  current note index within the track
//   dbg_state  out  current FSM state (FETCH=0, LOAD=1, PLAY=2, PAUSED=3)
//
// ROM access: rom_addr is held constant throughout FETCH; the ROM registers
// it at the edge ending FETCH and the word is captured at the edge ending
// LOAD. Every note therefore costs two silent cycles before it sounds.

module player_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int TRACK_W  = 2,
    parameter int NOTE_W   = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic                      next_btn,
    input  logic                      prev_btn,
    output logic [TRACK_W+NOTE_W-1:0] rom_addr,
    input  logic [9:0]                rom_data,
    output logic [5:0]                pitch_out,
    output logic                      tone_en,
    output logic [TRACK_W-1:0]        track,
    output logic [NOTE_W-1:0]         note_idx,
    output logic [1:0]                dbg_state
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_LOAD   = 2'd1,
        S_PLAY   = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    state_t                     state_q;
    logic [TRACK_W-1:0]         track_q;
    logic [NOTE_W-1:0]          note_idx_q;
    logic [5:0]                 pitch_q;
    logic [3:0]                 dur_cnt_q;
    logic [PRE_W-1:0]           presc_q;
    logic                       tone_en_q;
    logic                       next_q;
    logic                       prev_q;

    logic                       next_rise;
    logic                       prev_rise;
    logic                       trk_evt;
    logic                       note_done;
    logic [5:0]                 rom_pitch;
    logic [3:0]                 rom_dur;
    logic [TRACK_W+NOTE_W-1:0]  pos_next;

    assign next_rise = next_btn & ~next_q;
    assign prev_rise = prev_btn & ~prev_q;
    // Simultaneous next and prev cancel each other out.
    assign trk_evt   = next_rise ^ prev_rise;

    assign rom_pitch = rom_data[9:4];
    assign rom_dur   = rom_data[3:0];

    // Last prescaler tick of the last duration unit of the sounding note.
    assign note_done = (presc_q == PRE_LAST) && (dur_cnt_q == 4'd1);

    // Advancing the concatenated position wraps the note index into the
    // next track exactly like an end marker does.
    assign pos_next  = {track_q, note_idx_q} + (TRACK_W + NOTE_W)'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            track_q    <= '0;
            note_idx_q <= '0;
            pitch_q    <= '0;
            dur_cnt_q  <= '0;
            presc_q    <= '0;
            tone_en_q  <= 1'b0;
            next_q     <= 1'b0;
            prev_q     <= 1'b0;
        end else begin
            next_q <= next_btn;
            prev_q <= prev_btn;

            if (trk_evt) begin
                // Track change wins over note advance and end marker.
                track_q    <= next_rise ? track_q + TRACK_W'(1)
                                        : track_q - TRACK_W'(1);
                note_idx_q <= '0;
                state_q    <= S_FETCH;
                tone_en_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        state_q   <= S_LOAD;
                        tone_en_q <= 1'b0;
                    end

                    S_LOAD: begin
                        if (rom_dur != 4'd0) begin
                            pitch_q   <= rom_pitch;
                            dur_cnt_q <= rom_dur;
                            presc_q   <= '0;
                            state_q   <= play ? S_PLAY : S_PAUSED;
                            tone_en_q <= play;
                        end else begin
                            note_idx_q <= '0;
                            track_q    <= track_q + TRACK_W'(1);
                            state_q    <= S_FETCH;
                            tone_en_q  <= 1'b0;
                        end
                    end

                    S_PLAY: begin
                        // The cycle spent in PLAY always counts toward the
                        // note, even the one in which play drops; timing
                        // freezes only once PAUSED is reached.
                        if (presc_q == PRE_LAST) begin
                            presc_q <= '0;
                            if (!note_done) begin
                                dur_cnt_q <= dur_cnt_q - 4'd1;
                            end
                        end else begin
                            presc_q <= presc_q + PRE_W'(1);
                        end

                        if (note_done) begin
                            {track_q, note_idx_q} <= pos_next;
                            state_q   <= S_FETCH;
                            tone_en_q <= 1'b0;
                        end else if (!play) begin
                            state_q   <= S_PAUSED;
                            tone_en_q <= 1'b0;
                        end else begin
                            tone_en_q <= 1'b1;
                        end
                    end

                    S_PAUSED: begin
                        if (play) begin
                            state_q   <= S_PLAY;
                            tone_en_q <= 1'b1;
                        end else begin
                            tone_en_q <= 1'b0;
                        end
                    end

                    default: begin
                        state_q   <= S_FETCH;
                        tone_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr  = {track_q, note_idx_q};
    assign pitch_out = pitch_q;
    assign tone_en   = tone_en_q;
    assign track     = track_q;
    assign note_idx  = note_idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_player_sequencer.sv
// Testbench for player_sequencer: directed steps in one initial block with
// a small synchronous ROM model holding four short tracks.

module tb_player_sequencer;

    localparam int TICK_DIV = 4;
    localparam int TRACK_W  = 2;
    localparam int NOTE_W   = 6;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd3;

    logic                      clk;
    logic                      reset;
    logic                      play;
    logic                      next_btn;
    logic                      prev_btn;
    logic [TRACK_W+NOTE_W-1:0] rom_addr;
    logic [9:0]                rom_data;
    logic [5:0]                pitch_out;
    logic                      tone_en;
    logic [TRACK_W-1:0]        track;
    logic [NOTE_W-1:0]         note_idx;
    logic [1:0]                dbg_state;

    logic [9:0] rom_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    player_sequencer #(
        .TICK_DIV(TICK_DIV),
        .TRACK_W (TRACK_W),
        .NOTE_W  (NOTE_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .play     (play),
        .next_btn (next_btn),
        .prev_btn (prev_btn),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pitch_out(pitch_out),
        .tone_en  (tone_en),
        .track    (track),
        .note_idx (note_idx),
        .dbg_state(dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // n cycles with a fixed expected tone_en / pitch_out.
    task automatic span(input int n, input logic t, input logic [5:0] p, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_tone"}, 32'(tone_en), 32'(t));
            chk({tag, "_pitch"}, 32'(pitch_out), 32'(p));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = '0;
        // track 0: (5,2) (9,1) end
        rom_mem[0]   = {6'd5, 4'd2};
        rom_mem[1]   = {6'd9, 4'd1};
        // track 1: (12,1) (13,3) end
        rom_mem[64]  = {6'd12, 4'd1};
        rom_mem[65]  = {6'd13, 4'd3};
        // track 2: (20,1) end
        rom_mem[128] = {6'd20, 4'd1};
        // track 3: (33,2) end
        rom_mem[192] = {6'd33, 4'd2};

        reset    = 1'b1;
        play     = 1'b1;
        next_btn = 1'b0;
        prev_btn = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_tone",  32'(tone_en),   32'd0);
        chk("rst_track", 32'(track),     32'd0);
        chk("rst_note",  32'(note_idx),  32'd0);
        chk("rst_pitch", 32'(pitch_out), 32'd0);
        chk("rst_addr",  32'(rom_addr),  32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_FETCH));
        reset = 1'b0;

        // Track 0 playback: 8 high @5, 2 low, 4 high @9, 2 low, 2 more low
        step();
        chk("t1_load_state", 32'(dbg_state), 32'(ST_LOAD));
        chk("t1_load_tone",  32'(tone_en),   32'd0);
        span(8, 1'b1, 6'd5, "t1_n0");
        span(2, 1'b0, 6'd5, "t1_gap0");
        chk("t1_note1", 32'(note_idx), 32'd1);
        span(4, 1'b1, 6'd9, "t1_n1");
        span(4, 1'b0, 6'd9, "t1_end");
        chk("t1_track_after_end", 32'(track),    32'd1);
        chk("t1_note_after_end",  32'(note_idx), 32'd0);
        span(1, 1'b1, 6'd12, "t1_trk1_n0");

        // Reset mid-note
        reset = 1'b1;
        step();
        chk("rm_tone",  32'(tone_en),   32'd0);
        chk("rm_track", 32'(track),     32'd0);
        chk("rm_note",  32'(note_idx),  32'd0);
        chk("rm_pitch", 32'(pitch_out), 32'd0);
        reset = 1'b0;
        span(1, 1'b0, 6'd0, "rm_load");
        span(1, 1'b1, 6'd5, "rm_first");

        // Pause mid-note: 3 high, pause 10 low, resume 5 high
        span(2, 1'b1, 6'd5, "pz_pre");
        play = 1'b0;
        span(10, 1'b0, 6'd5, "pz_hold");
        chk("pz_state", 32'(dbg_state), 32'(ST_PAUSED));
        play = 1'b1;
        span(5, 1'b1, 6'd5, "pz_resume");
        span(1, 1'b0, 6'd5, "pz_done");
        chk("pz_note1", 32'(note_idx), 32'd1);

        // next_btn during PLAY of track 0 note 1
        span(1, 1'b0, 6'd5, "nx_load");
        span(1, 1'b1, 6'd9, "nx_play");
        next_btn = 1'b1;
        step();
        chk("nx_tone",  32'(tone_en),   32'd0);
        chk("nx_track", 32'(track),     32'd1);
        chk("nx_note",  32'(note_idx),  32'd0);
        chk("nx_state", 32'(dbg_state), 32'(ST_FETCH));
        span(1, 1'b0, 6'd9, "nx_load2");
        span(4, 1'b1, 6'd12, "nx_trk1_n0");
        span(2, 1'b0, 6'd12, "nx_gap");
        chk("nx_held_track", 32'(track),    32'd1);
        chk("nx_held_note",  32'(note_idx), 32'd1);
        next_btn = 1'b0;
        span(1, 1'b1, 6'd13, "nx_trk1_n1");

        // next and prev rising together during PLAY: no effect
        next_btn = 1'b1;
        prev_btn = 1'b1;
        step();
        chk("both_tone",  32'(tone_en),  32'd1);
        chk("both_track", 32'(track),    32'd1);
        chk("both_note",  32'(note_idx), 32'd1);
        span(10, 1'b1, 6'd13, "both_rest");
        span(1, 1'b0, 6'd13, "both_done");
        chk("both_note2", 32'(note_idx), 32'd2);
        next_btn = 1'b0;
        prev_btn = 1'b0;
        span(2, 1'b0, 6'd13, "both_end");
        chk("both_trk2", 32'(track), 32'd2);

        // prev_btn at track 0 with play=0, held 20 cycles
        play = 1'b0;
        do_reset();
        step();
        step();
        chk("pv_paused", 32'(dbg_state), 32'(ST_PAUSED));
        chk("pv_pitch0", 32'(pitch_out), 32'd5);
        prev_btn = 1'b1;
        step();
        chk("pv_track", 32'(track),     32'd3);
        chk("pv_note",  32'(note_idx),  32'd0);
        chk("pv_state", 32'(dbg_state), 32'(ST_FETCH));
        for (int i = 0; i < 19; i++) begin
            step();
            chk("pv_held_tone",  32'(tone_en), 32'd0);
            chk("pv_held_track", 32'(track),   32'd3);
        end
        chk("pv_load_pitch", 32'(pitch_out), 32'd33);
        chk("pv_load_state", 32'(dbg_state), 32'(ST_PAUSED));
        prev_btn = 1'b0;
        play = 1'b1;
        span(8, 1'b1, 6'd33, "pv_play");
        span(3, 1'b0, 6'd33, "pv_end");
        chk("pv_wrap_track", 32'(track),    32'd0);
        chk("pv_wrap_note",  32'(note_idx), 32'd0);
        span(1, 1'b0, 6'd33, "pv_wrap_load");
        span(1, 1'b1, 6'd5, "pv_wrap_play");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
